bram_1kb_arbiter: RTL and testbench
===================================

Name: bram_1kb_arbiter

Overview:
- Shares one 1 KB BlockRAM tile between two requesters (A, B), each with a valid/ready request channel and a fixed-latency read response.
- Operates the tile in 16-bit read and write mode, so the logical memory is 512 x 16.
- Packs the 9-bit address and write strobe into the tile's side-band data bits and drives its static configuration inputs.
- Sits between fabric user logic and the BlockRAM tile.

Parameters:
- REG_OUT, 0: 1 selects the tile's output register, which adds 1 cycle of read latency.
- RD_LAT, 1+REG_OUT: read latency in cycles, from grant edge to rsp_valid. Derived; do not override.

Ports:
- clk  in  1  Clock.
- rst  in  1  Synchronous, active-high reset.
- a_req_valid  in  1  Requester A has a request.
- a_req_ready  out  1  Requester A's request is accepted this cycle.
- a_req_we  in  1  1 = write, 0 = read.
- a_req_addr  in  9  Word address, 0..511.
- a_req_wdata  in  16  Write data.
- a_rsp_valid  out  1  Read data for A is valid this cycle.
- a_rsp_rdata  out  16  Read data for A.
- b_*  (same 7 ports as A, for requester B)
- ram_rd_addr  out  8  To tile rd_addr.
- ram_wr_addr  out  8  To tile wr_addr.
- ram_wr_data  out  32  To tile wr_data, packed side-band word.
- ram_rd_data  in  32  From tile rd_data; bits [15:0] are used.
- ram_cfg  out  6  To tile C0..C5, index 0 = C0.
- busy  out  1  Clear sequence in progress, or a read is in flight.

Behaviour:
- ram_cfg is constant: C0=0, C1=1 (16-bit write); C2=0, C3=1 (16-bit read); C4=0 (dynamic write enable); C5=REG_OUT.
- ram_wr_data packing:
  - [15:0] = wdata
  - [16] = write addr[8]
  - [20] = write strobe
  - [24] = read addr[8]
  - every other bit = 0
- ram_wr_addr = addr[7:0] on a granted write; ram_rd_addr = addr[7:0] on a granted read.
- When no operation is granted: bit [20] = 0 and all ram outputs are held at 0.
- At most one operation is granted per cycle. Grant = valid && ready.
- Arbitration is round-robin:
  - A 1-bit last-grant register; reset value = B, so A wins the first tie.
  - On a tie, the requester not granted last wins.
  - A lone requester is granted every cycle.
  - The ready signals are combinational from the valids and the arbiter state. Ready is high only for the winner, and only in state RUN.
- Write: a single cycle, with no response.
- Read: a/b_rsp_valid pulses exactly RD_LAT cycles after the grant edge, together with rsp_rdata = ram_rd_data[15:0].
  - Routed by an RD_LAT-deep shift register of {valid, requester id}.
  - rsp_rdata is 0 when rsp_valid is low.
- Back-to-back reads pipeline at full rate. The two rsp_valid outputs are never high in the same cycle.
- Read and write to the same address in the same cycle cannot occur (one op per cycle). A read granted the cycle after a write returns the new data.
- Reset values:
  - ready, rsp_valid, rsp_rdata, ram_rd_addr, ram_wr_addr, ram_wr_data all 0.
  - Response pipeline flushed.
  - busy = 1 when clear is compiled in, otherwise 0.
- Reset mid-operation: in-flight reads are dropped, with no rsp_valid after rst.
- FSM states: CLEAR, RUN.
  - Reset enters CLEAR when the optional feature is compiled in, otherwise RUN.
  - RUN is absorbing until rst.
- busy = (state==CLEAR) || any response-pipeline valid.

Optional Feature:
- Macro: BRAM_ARB_CLEAR_ON_RESET_EN.
- Defined:
  - After rst deasserts, the FSM stays in CLEAR for 512 cycles and writes 0 to addresses 0..511 in ascending order, one per cycle, using a 9-bit counter.
  - Both ready outputs are held 0 during CLEAR.
  - Requests are held off, not dropped; the valid/ready protocol keeps them pending.
  - In the cycle after the write to address 511, the FSM moves to RUN.
  - rst during CLEAR restarts the sequence at address 0.
- Not defined: the counter and CLEAR state are not built; reset goes directly to RUN and the memory contents are undefined.

Test Plan:
- A writes 0xBEEF to 0x105, then A reads 0x105 -> ram_wr_data[20]=1, [16]=1, [15:0]=0xBEEF, ram_wr_addr=0x05; a_rsp_valid RD_LAT cycles after the read grant with 0xBEEF; b_rsp_valid stays 0.
- A and B both hold valid reads for 6 cycles -> grants alternate A,B,A,B,A,B; responses return in the same order, each tagged to the correct requester.
- B alone issues reads on 4 consecutive cycles to 0x000..0x003, with REG_OUT=1 -> b_req_ready=1 every cycle; b_rsp_valid is high for 4 consecutive cycles starting 2 cycles after the first grant, with data in address order.
- rst is asserted for 1 cycle while 2 reads are in flight -> no rsp_valid after rst; all ram outputs are 0 in the cycle after rst.
- With BRAM_ARB_CLEAR_ON_RESET_EN and A valid from reset -> a_req_ready=0 and busy=1 for 512 cycles; the first A grant is in the cycle busy falls; an A read of 0x1FF returns 0x0000.
- Without the macro, A valid in the first cycle after rst -> a_req_ready=1 immediately; busy=0.

Source files
------------

// File: rtl/bram_1kb_arbiter.sv
// rtl/bram_1kb_arbiter.sv - two-port round-robin arbiter in front of a 1 KB BlockRAM tile used as 512 x 16
// Optional build macro: BRAM_ARB_CLEAR_ON_RESET_EN (zero-fill the memory after reset)
module bram_1kb_arbiter #(
  parameter int REG_OUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req_valid,
  output logic        a_req_ready,
  input  logic        a_req_we,
  input  logic [8:0]  a_req_addr,
  input  logic [15:0] a_req_wdata,
  output logic        a_rsp_valid,
  output logic [15:0] a_rsp_rdata,
  input  logic        b_req_valid,
  output logic        b_req_ready,
  input  logic        b_req_we,
  input  logic [8:0]  b_req_addr,
  input  logic [15:0] b_req_wdata,
  output logic        b_rsp_valid,
  output logic [15:0] b_rsp_rdata,
  output logic [7:0]  ram_rd_addr,
  output logic [7:0]  ram_wr_addr,
  output logic [31:0] ram_wr_data,
  input  logic [31:0] ram_rd_data,
  output logic [5:0]  ram_cfg,
  output logic        busy
);

  localparam int RD_LAT = 1 + REG_OUT;

  typedef enum logic {CLEAR, RUN} state_t;

`ifdef BRAM_ARB_CLEAR_ON_RESET_EN
  localparam state_t RESET_STATE = CLEAR;
  localparam logic   CLEAR_EN    = 1'b1;
  logic [8:0] clr_addr;
`else
  localparam state_t RESET_STATE = RUN;
  localparam logic   CLEAR_EN    = 1'b0;
  logic [8:0] clr_addr;
  assign clr_addr = 9'd0;
`endif

  state_t            state;
  logic              last_b;
  logic [RD_LAT-1:0] pipe_v;
  logic [RD_LAT-1:0] pipe_id;

  logic        run;
  logic        clearing;
  logic        pick_a;
  logic        g_any;
  logic        g_we;
  logic [8:0]  g_addr;
  logic [15:0] g_wdata;
  logic        rd_grant;
  logic        unused_rd_hi;

  assign run      = (state == RUN) && !rst;
  assign clearing = (state == CLEAR) && !rst;

  // On a tie the requester that was not granted last wins.
  assign pick_a      = a_req_valid && (!b_req_valid || last_b);
  assign a_req_ready = run && pick_a;
  assign b_req_ready = run && b_req_valid && !pick_a;

  assign g_any    = a_req_ready || b_req_ready;
  assign g_we     = b_req_ready ? b_req_we    : a_req_we;
  assign g_addr   = b_req_ready ? b_req_addr  : a_req_addr;
  assign g_wdata  = b_req_ready ? b_req_wdata : a_req_wdata;
  assign rd_grant = g_any && !g_we;

  assign ram_cfg = {(REG_OUT != 0), 5'b01010};

  // Address bit 8 and the write strobe ride in the side-band bits of wr_data.
  always_comb begin
    ram_rd_addr = 8'd0;
    ram_wr_addr = 8'd0;
    ram_wr_data = 32'd0;
    if (clearing) begin
      ram_wr_addr     = clr_addr[7:0];
      ram_wr_data[16] = clr_addr[8];
      ram_wr_data[20] = 1'b1;
    end else if (g_any && g_we) begin
      ram_wr_addr       = g_addr[7:0];
      ram_wr_data[15:0] = g_wdata;
      ram_wr_data[16]   = g_addr[8];
      ram_wr_data[20]   = 1'b1;
    end else if (g_any) begin
      ram_rd_addr     = g_addr[7:0];
      ram_wr_data[24] = g_addr[8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RESET_STATE;
      last_b  <= 1'b1;
      pipe_v  <= '0;
      pipe_id <= '0;
`ifdef BRAM_ARB_CLEAR_ON_RESET_EN
      clr_addr <= 9'd0;
`endif
    end else begin
      if (a_req_ready) last_b <= 1'b0;
      else if (b_req_ready) last_b <= 1'b1;
      pipe_v  <= (pipe_v << 1) | RD_LAT'(rd_grant);
      pipe_id <= (pipe_id << 1) | RD_LAT'(b_req_ready);
`ifdef BRAM_ARB_CLEAR_ON_RESET_EN
      if (state == CLEAR) begin
        clr_addr <= clr_addr + 9'd1;
        if (clr_addr == 9'd511) state <= RUN;
      end
`endif
    end
  end

  assign a_rsp_valid  = !rst && pipe_v[RD_LAT-1] && !pipe_id[RD_LAT-1];
  assign b_rsp_valid  = !rst && pipe_v[RD_LAT-1] &&  pipe_id[RD_LAT-1];
  assign a_rsp_rdata  = a_rsp_valid ? ram_rd_data[15:0] : 16'd0;
  assign b_rsp_rdata  = b_rsp_valid ? ram_rd_data[15:0] : 16'd0;
  assign unused_rd_hi = ^ram_rd_data[31:16];

  assign busy = rst ? CLEAR_EN : ((state == CLEAR) || (|pipe_v));

endmodule

// File: tb/tb_bram_1kb_arbiter.sv
// tb/tb_bram_1kb_arbiter.sv - randomized bench for bram_1kb_arbiter with a tile model and a behavioural reference
module tb_bram_1kb_arbiter;
  localparam int REG_OUT = 1;
  localparam int RD_LAT  = 1 + REG_OUT;
`ifdef BRAM_ARB_CLEAR_ON_RESET_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid;
  logic [8:0]  a_req_addr;
  logic [15:0] a_req_wdata, a_rsp_rdata;
  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid;
  logic [8:0]  b_req_addr;
  logic [15:0] b_req_wdata, b_rsp_rdata;
  logic [7:0]  ram_rd_addr, ram_wr_addr;
  logic [31:0] ram_wr_data, ram_rd_data;
  logic [5:0]  ram_cfg;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  bram_1kb_arbiter #(.REG_OUT(REG_OUT)) dut (
    .clk(clk), .rst(rst),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
    .ram_rd_addr(ram_rd_addr), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_data(ram_rd_data), .ram_cfg(ram_cfg), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_word(int a);
    return 16'((a * 40503) ^ 23130);
  endfunction

  // Tile: synchronous read, optional output register, 9-bit address split across ports.
  logic [15:0] tile_mem [512];
  logic [15:0] rd_q, rd_q2;
  always @(posedge clk) begin
    if (ram_wr_data[20]) tile_mem[{ram_wr_data[16], ram_wr_addr}] <= ram_wr_data[15:0];
    rd_q  <= tile_mem[{ram_wr_data[24], ram_rd_addr}];
    rd_q2 <= rd_q;
  end
  assign ram_rd_data = {16'hDEAD, (REG_OUT != 0) ? rd_q2 : rd_q};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct {int due; bit id; logic [15:0] data;} rsp_t;
  rsp_t        q[$];
  logic [15:0] ref_mem [512];
  bit          last_b   = 1'b1;
  int          clr_left = 512;
  int          cyc      = 0;

  task automatic check_cycle();
    bit clearing, run, ga, gb, g, we, ea, eb, e_busy;
    logic [8:0]  addr;
    logic [15:0] wd, ed;
    logic [7:0]  e_rd, e_wr;
    logic [31:0] e_wd;
    int ca;
    clearing = CLR_EN && !rst && (clr_left > 0);
    run = !rst && !clearing;
    if (a_req_valid && b_req_valid) begin
      ga = run && last_b;
      gb = run && !last_b;
    end else begin
      ga = run && a_req_valid;
      gb = run && b_req_valid;
    end
    g    = ga || gb;
    we   = gb ? b_req_we : a_req_we;
    addr = gb ? b_req_addr : a_req_addr;
    wd   = gb ? b_req_wdata : a_req_wdata;
    e_rd = 8'd0; e_wr = 8'd0; e_wd = 32'd0;
    if (clearing) begin
      ca   = 512 - clr_left;
      e_wr = ca[7:0];
      e_wd = 32'h0010_0000 | (32'(ca[8]) << 16);
    end else if (g && we) begin
      e_wr = addr[7:0];
      e_wd = 32'h0010_0000 | (32'(addr[8]) << 16) | 32'(wd);
    end else if (g) begin
      e_rd = addr[7:0];
      e_wd = 32'(addr[8]) << 24;
    end
    ea = 1'b0; eb = 1'b0; ed = 16'd0;
    if (!rst && q.size() > 0 && q[0].due == cyc) begin
      ea = !q[0].id;
      eb = q[0].id;
      ed = q[0].data;
    end
    e_busy = rst ? CLR_EN : (clearing || q.size() > 0);
    chk("a_req_ready", a_req_ready, ga);
    chk("b_req_ready", b_req_ready, gb);
    chk("ram_rd_addr", ram_rd_addr, e_rd);
    chk("ram_wr_addr", ram_wr_addr, e_wr);
    chk("ram_wr_data", ram_wr_data, e_wd);
    chk("ram_cfg", ram_cfg, {REG_OUT[0], 5'b01010});
    chk("a_rsp_valid", a_rsp_valid, ea);
    chk("b_rsp_valid", b_rsp_valid, eb);
    chk("a_rsp_rdata", a_rsp_rdata, ea ? ed : 16'd0);
    chk("b_rsp_rdata", b_rsp_rdata, eb ? ed : 16'd0);
    chk("busy", busy, e_busy);
    if (rst) begin
      last_b = 1'b1;
      q.delete();
      clr_left = 512;
    end else begin
      if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
      if (clearing) begin
        ref_mem[512 - clr_left] = 16'd0;
        clr_left--;
      end
      if (ga) last_b = 1'b0;
      if (gb) last_b = 1'b1;
      if (g && we) ref_mem[addr] = wd;
      else if (g) q.push_back('{due: cyc + RD_LAT, id: gb, data: ref_mem[addr]});
    end
    cyc++;
  endtask

  always @(negedge clk) begin
    #2;
    check_cycle();
  end

  task automatic drive(input bit r,
                       input bit av, input bit awe, input logic [8:0] aa, input logic [15:0] ad,
                       input bit bv, input bit bwe, input logic [8:0] ba, input logic [15:0] bd);
    @(negedge clk);
    rst = r;
    a_req_valid = av; a_req_we = awe; a_req_addr = aa; a_req_wdata = ad;
    b_req_valid = bv; b_req_we = bwe; b_req_addr = ba; b_req_wdata = bd;
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 9'd0, 16'd0, 0, 0, 9'd0, 16'd0);
  endtask

  task automatic wait_clear_done();
    for (int k = 0; k < 600 && busy; k++) idle(1);
    chk("clear_done", busy, 1'b0);
  endtask

  typedef struct {bit v; bit we; logic [8:0] addr; logic [15:0] data;} req_t;

  function automatic req_t new_req();
    req_t r;
    r.v    = 1'b1;
    r.we   = 1'($urandom_range(0, 1));
    r.addr = ($urandom_range(0, 1) != 0) ? 9'($urandom_range(0, 15)) : 9'($urandom_range(0, 511));
    r.data = 16'($urandom);
    return r;
  endfunction

  req_t pa, pb;
  int   ia, ib;
  bit   rnd_rst;

  initial begin
    for (int i = 0; i < 512; i++) begin
      tile_mem[i] = init_word(i);
      ref_mem[i]  = init_word(i);
    end
    rst = 1'b1;
    a_req_valid = 0; a_req_we = 0; a_req_addr = 0; a_req_wdata = 0;
    b_req_valid = 0; b_req_we = 0; b_req_addr = 0; b_req_wdata = 0;
    drive(1, 1, 0, 9'h010, 16'd0, 1, 0, 9'h020, 16'd0);
    drive(1, 1, 0, 9'h010, 16'd0, 1, 0, 9'h020, 16'd0);
    chk("rst_a_ready", a_req_ready, 1'b0);
    chk("rst_wr_data", ram_wr_data, 32'd0);

`ifdef BRAM_ARB_CLEAR_ON_RESET_EN
    ia = 0;
    for (int i = 0; i < 512; i++) begin
      drive(0, 1, 0, 9'h010, 16'd0, 1, 0, 9'h020, 16'd0);
      if (a_req_ready !== 1'b0 || busy !== 1'b1) ia++;
    end
    chk("clear_hold_off", ia, 0);
`endif

    // Both requesters hold reads: grants must alternate starting with A.
    ia = 0; ib = 0;
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 0, 9'(9'h010 + ia), 16'd0, 1, 0, 9'(9'h020 + ib), 16'd0);
      if (i == 0) chk("first_grant_busy", busy, 1'b0);
      chk("tie_a_ready", a_req_ready, (i % 2) == 0);
      chk("tie_b_ready", b_req_ready, (i % 2) == 1);
      if (a_req_ready) ia++;
      if (b_req_ready) ib++;
    end
    idle(RD_LAT + 1);

    // A writes 0xBEEF to 0x105 and reads it back.
    drive(0, 1, 1, 9'h105, 16'hBEEF, 0, 0, 9'd0, 16'd0);
    chk("wr_grant", a_req_ready, 1'b1);
    chk("wr_packed", ram_wr_data, 32'h0011_BEEF);
    chk("wr_addr", ram_wr_addr, 8'h05);
    drive(0, 1, 0, 9'h105, 16'd0, 0, 0, 9'd0, 16'd0);
    chk("rd_addr", ram_rd_addr, 8'h05);
    chk("rd_packed", ram_wr_data, 32'h0100_0000);
    for (int k = 1; k <= RD_LAT; k++) begin
      idle(1);
      chk("beef_valid", a_rsp_valid, k == RD_LAT);
      if (k == RD_LAT) chk("beef_data", a_rsp_rdata, 16'hBEEF);
      chk("beef_b_quiet", b_rsp_valid, 1'b0);
    end

    // A reads the top word.
    drive(0, 1, 0, 9'h1FF, 16'd0, 0, 0, 9'd0, 16'd0);
    chk("top_rd_addr", ram_rd_addr, 8'hFF);
    chk("top_rd_packed", ram_wr_data, 32'h0100_0000);
    idle(RD_LAT);
    chk("top_rsp_valid", a_rsp_valid, 1'b1);
    chk("top_rsp_data", a_rsp_rdata, CLR_EN ? 16'h0000 : init_word(511));

    // B alone streams four reads.
    for (int j = 0; j < 4 + RD_LAT; j++) begin
      drive(0, 0, 0, 9'd0, 16'd0, j < 4, 0, 9'(j), 16'd0);
      if (j < 4) chk("b_alone_ready", b_req_ready, 1'b1);
      if (j >= RD_LAT) begin
        chk("b_alone_rsp", b_rsp_valid, 1'b1);
        chk("b_alone_data", b_rsp_rdata, CLR_EN ? 16'h0000 : init_word(j - RD_LAT));
      end else begin
        chk("b_alone_early", b_rsp_valid, 1'b0);
      end
    end
    idle(1);

    // Reset with two reads in flight.
    drive(0, 1, 0, 9'h050, 16'd0, 0, 0, 9'd0, 16'd0);
    drive(0, 1, 0, 9'h051, 16'd0, 0, 0, 9'd0, 16'd0);
    drive(1, 0, 0, 9'd0, 16'd0, 0, 0, 9'd0, 16'd0);
    chk("rst_drop_a", a_rsp_valid, 1'b0);
    idle(1);
    chk("after_rst_rsp", a_rsp_valid, 1'b0);
`ifndef BRAM_ARB_CLEAR_ON_RESET_EN
    chk("after_rst_rd_addr", ram_rd_addr, 8'd0);
    chk("after_rst_wr_addr", ram_wr_addr, 8'd0);
    chk("after_rst_wr_data", ram_wr_data, 32'd0);
    chk("after_rst_busy", busy, 1'b0);
`endif
    idle(RD_LAT);
    chk("after_rst_rsp_late", a_rsp_valid, 1'b0);
    wait_clear_done();

    // Random traffic with requests held until accepted.
    pa = '{default: '0};
    pb = '{default: '0};
    for (int n = 0; n < 1500; n++) begin
      rnd_rst = ($urandom_range(0, 299) == 0);
      if (!pa.v && $urandom_range(0, 9) < 6) pa = new_req();
      if (!pb.v && $urandom_range(0, 9) < 6) pb = new_req();
      drive(rnd_rst, pa.v, pa.we, pa.addr, pa.data, pb.v, pb.we, pb.addr, pb.data);
      if (a_req_ready) pa.v = 1'b0;
      if (b_req_ready) pb.v = 1'b0;
    end
    idle(RD_LAT + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
